// File: rtl/glyph_reader.sv
// glyph_reader: recognises a programmable blank-delimited glyph in a column stream
// and keeps a saturating count of recognised glyphs.
module glyph_reader #(
    parameter int W      = 3,
    parameter int MAXLEN = 4,
    parameter int LW     = 3,
    parameter int CNTW   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  valid,
    input  logic [W-1:0]          bits,
    input  logic [MAXLEN*W-1:0]   pattern,
    input  logic [LW-1:0]         pat_len,
    output logic                  found,
    output logic                  garbage,
    output logic [CNTW-1:0]       count
);
    typedef enum logic [2:0] {GARBAGE, BLANK, MATCH, FULL, DONE} state_t;

    state_t                state, n_state;
    logic [LW-1:0]         idx, n_idx, slen, n_slen, idx_inc;
    logic [MAXLEN*W-1:0]   spat, n_spat;
    logic [CNTW-1:0]       n_count;
    logic [W-1:0]          col;
    logic                  blank, legal;

    assign blank   = bits == '0;
    assign legal   = pat_len != '0 && pat_len <= LW'(MAXLEN);
    assign col     = W'(spat >> (idx * W));
    assign idx_inc = idx + 1'b1;
    assign found   = state == DONE;
    assign garbage = state == GARBAGE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GARBAGE;
            idx   <= '0;
            spat  <= '0;
            slen  <= '0;
            count <= '0;
        end else begin
            state <= n_state;
            idx   <= n_idx;
            spat  <= n_spat;
            slen  <= n_slen;
            count <= n_count;
        end
    end

    // Pattern match is tested before blank in MATCH so interior all-zero columns are legal.
    always_comb begin
        n_state = state;
        n_idx   = idx;
        n_spat  = spat;
        n_slen  = slen;
        n_count = count;
        if (restart) begin
            n_state = GARBAGE;
            n_idx   = '0;
        end else if (valid) begin
            case (state)
                GARBAGE: n_state = blank ? BLANK : GARBAGE;
                BLANK, DONE: begin
                    if (blank) begin
                        n_state = BLANK;
                    end else if (legal && bits == pattern[W-1:0]) begin
                        n_spat  = pattern;
                        n_slen  = pat_len;
                        n_idx   = LW'(1);
                        n_state = pat_len == LW'(1) ? FULL : MATCH;
                    end else begin
                        n_state = GARBAGE;
                    end
                end
                MATCH: begin
                    if (bits == col) begin
                        n_idx   = idx_inc;
                        n_state = idx_inc == slen ? FULL : MATCH;
                    end else begin
                        n_state = blank ? BLANK : GARBAGE;
                    end
                end
                FULL: begin
                    n_state = blank ? DONE : GARBAGE;
                    n_count = blank && count != '1 ? count + 1'b1 : count;
                end
                default: n_state = GARBAGE;
            endcase
        end
    end
endmodule

// File: tb/tb_glyph_reader.sv
// tb_glyph_reader: scoreboarded random + directed bench; a second instance with a
// 2-bit counter shares all inputs to exercise saturation.
module tb_glyph_reader;
    localparam int W = 3, MAXLEN = 4, LW = 3;

    logic clk = 0, reset = 0, restart = 0, valid = 0;
    logic [W-1:0]        bits = '0;
    logic [MAXLEN*W-1:0] pattern = '0;
    logic [LW-1:0]       pat_len = '0;
    logic                found, garbage, found2, garbage2;
    logic [7:0]          count;
    logic [1:0]          count2;

    glyph_reader #(.W(W), .MAXLEN(MAXLEN), .LW(LW), .CNTW(8)) dut (
        .clk(clk), .reset(reset), .restart(restart), .valid(valid), .bits(bits),
        .pattern(pattern), .pat_len(pat_len), .found(found), .garbage(garbage), .count(count));
    glyph_reader #(.W(W), .MAXLEN(MAXLEN), .LW(LW), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .restart(restart), .valid(valid), .bits(bits),
        .pattern(pattern), .pat_len(pat_len), .found(found2), .garbage(garbage2), .count(count2));

    always #5 clk = ~clk;

    typedef struct packed {logic f; logic g; logic [7:0] c8; logic [1:0] c2;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_cmp = 0, n_err = 0;

    // Model: m_k = glyph columns matched since the last blank, 0 when sitting on a blank.
    bit                  m_garb, m_found;
    int                  m_k, m_len, m_c8, m_c2;
    logic [MAXLEN*W-1:0] m_pat;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("found", found, e.f);
            chk("garbage", garbage, e.g);
            chk("count", count, e.c8);
            chk("found_sat", found2, e.f);
            chk("garbage_sat", garbage2, e.g);
            chk("count_sat", count2, e.c2);
        end
    end

    task automatic model_reset();
        m_garb = 1; m_found = 0; m_k = 0; m_len = 0; m_pat = '0; m_c8 = 0; m_c2 = 0;
    endtask

    task automatic model_step(bit rs, bit v, logic [W-1:0] c);
        if (rs) begin
            m_garb = 1; m_k = 0; m_found = 0;
        end else if (v) begin
            m_found = 0;
            if (m_garb) begin
                if (c == 0) begin m_garb = 0; m_k = 0; end
            end else if (m_k == 0) begin
                if (c != 0) begin
                    if (pat_len >= 1 && pat_len <= MAXLEN && c == pattern[W-1:0]) begin
                        m_pat = pattern; m_len = pat_len; m_k = 1;
                    end else m_garb = 1;
                end
            end else if (m_k < m_len && c == m_pat[m_k*W +: W]) begin
                m_k++;
            end else if (c == 0) begin
                if (m_k == m_len) begin
                    m_found = 1;
                    m_c8 = m_c8 < 255 ? m_c8 + 1 : 255;
                    m_c2 = m_c2 < 3 ? m_c2 + 1 : 3;
                end
                m_k = 0;
            end else m_garb = 1;
        end
    endtask

    task automatic step(bit rs, bit v, logic [W-1:0] c);
        @(negedge clk); #1;
        restart = rs; valid = v; bits = c;
        @(posedge clk);
        model_step(rs, v, c);
        q.push_back('{m_found, m_garb, 8'(m_c8), 2'(m_c2)});
        #1 valid = 0; restart = 0;
    endtask

    task automatic col(logic [W-1:0] c); step(0, 1, c); endtask
    task automatic idle(int n); repeat (n) step(0, 0, 3'b000); endtask
    task automatic setp(int len, logic [MAXLEN*W-1:0] p); pat_len = LW'(len); pattern = p; endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 0;
        model_reset();
        #1;
        chk("async_garbage", garbage, 1);
        chk("async_found", found, 0);
        chk("async_count", count, 0);
        @(negedge clk); #1 reset = 1;
    endtask

    initial begin
        int r;
        logic [W-1:0] c;
        model_reset();
        #1;
        chk("rst_garbage", garbage, 1);
        chk("rst_found", found, 0);
        chk("rst_count", count, 0);
        @(negedge clk); #1 reset = 1;
        setp(1, {9'b0, 3'b111});
        col(3'b000); col(3'b111); col(3'b000);
        setp(3, {3'b000, 3'b101, 3'b101, 3'b111});
        col(3'b000); col(3'b111); col(3'b101); col(3'b101); col(3'b000);
        col(3'b111); col(3'b101); col(3'b000);
        col(3'b111); col(3'b101); col(3'b101); col(3'b000);
        col(3'b000); col(3'b010); col(3'b111); col(3'b000);
        setp(1, {9'b0, 3'b111});
        col(3'b000); col(3'b111); col(3'b111);
        col(3'b000); idle(3); col(3'b111); idle(3); col(3'b000); idle(3);
        col(3'b111); idle(3); col(3'b000); idle(3);
        col(3'b111); setp(1, {9'b0, 3'b010}); col(3'b000);
        setp(3, {3'b000, 3'b101, 3'b101, 3'b111});
        col(3'b111); step(1, 1, 3'b101); col(3'b000);
        setp(0, {9'b0, 3'b111});
        col(3'b000); col(3'b111); col(3'b000);
        setp(3, {3'b000, 3'b101, 3'b101, 3'b111});
        col(3'b000); col(3'b111);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                setp($urandom_range(0, 7), {3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom_range(1, 7))});
            if ($urandom_range(0, 499) == 0) do_reset();
            r = $urandom_range(0, 9);
            c = (m_k > 0 && m_k < m_len) ? m_pat[m_k*W +: W] : pattern[W-1:0];
            c = r < 3 ? 3'b000 : r < 8 ? c : 3'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, c);
        end
        repeat (2) @(negedge clk);
        if (q.size() != 0) chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
